// File: rtl/canvas_dump_tx.sv
// canvas_dump_tx: walks the MAX_X x MAX_Y tile RAM row by row and sends
// each cell as one 8N1 ASCII byte, with CR/LF after every row.
// Ports: clk_100MHz, reset_n (async, active low), start, abort,
//   ram_addr/ram_dout (RAM read port A), tx (UART line), busy, done.
module canvas_dump_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int MAX_X        = 80,
  parameter int MAX_Y        = 30
) (
  input  logic        clk_100MHz,
  input  logic        reset_n,
  input  logic        start,
  input  logic        abort,
  output logic [11:0] ram_addr,
  input  logic [6:0]  ram_dout,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    IDLE, FETCH, LATCH, SEND, CR, LF, FINISH
  } state_t;

  typedef enum logic [1:0] {
    K_CELL, K_CR, K_LF
  } kind_t;

  localparam logic [15:0] CNT_MAX  = 16'(CLKS_PER_BIT - 1);
  localparam logic [6:0]  LAST_COL = 7'(MAX_X - 1);
  localparam logic [4:0]  LAST_ROW = 5'(MAX_Y - 1);

  state_t      state;
  kind_t       kind;
  logic [4:0]  row;
  logic [6:0]  col;
  logic [15:0] cnt;
  logic [3:0]  bidx;
  logic [7:0]  sh;
  logic        abort_q;

  // Data bits leave from sh[0]; ones shift in from the top so
  // that after eight shifts sh[0] already holds the stop bit.
  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      kind     <= K_CELL;
      row      <= '0;
      col      <= '0;
      cnt      <= '0;
      bidx     <= '0;
      sh       <= '0;
      abort_q  <= 1'b0;
      ram_addr <= '0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (busy && abort) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (start) begin
            state    <= FETCH;
            busy     <= 1'b1;
            row      <= '0;
            col      <= '0;
            ram_addr <= '0;
            abort_q  <= 1'b0;
          end
        end
        FETCH: state <= LATCH;
        LATCH: begin
          sh    <= (ram_dout == 7'd0) ? 8'h20
                                      : {1'b0, ram_dout};
          kind  <= K_CELL;
          tx    <= 1'b0;
          cnt   <= '0;
          bidx  <= '0;
          state <= SEND;
        end
        CR: begin
          sh    <= 8'h0D;
          kind  <= K_CR;
          tx    <= 1'b0;
          cnt   <= '0;
          bidx  <= '0;
          state <= SEND;
        end
        LF: begin
          sh    <= 8'h0A;
          kind  <= K_LF;
          tx    <= 1'b0;
          cnt   <= '0;
          bidx  <= '0;
          state <= SEND;
        end
        SEND: begin
          if (cnt != CNT_MAX) begin
            cnt <= cnt + 16'd1;
          end else if (bidx != 4'd9) begin
            cnt  <= '0;
            bidx <= bidx + 4'd1;
            tx   <= sh[0];
            sh   <= {1'b1, sh[7:1]};
          end else begin
            cnt  <= '0;
            bidx <= '0;
            if (abort_q || abort) begin
              state   <= IDLE;
              busy    <= 1'b0;
              abort_q <= 1'b0;
            end else begin
              case (kind)
                K_CELL: begin
                  if (col == LAST_COL) begin
                    state <= CR;
                  end else begin
                    col      <= col + 7'd1;
                    ram_addr <= {row, col + 7'd1};
                    state    <= FETCH;
                  end
                end
                K_CR: state <= LF;
                K_LF: begin
                  if (row == LAST_ROW) begin
                    state <= FINISH;
                  end else begin
                    row      <= row + 5'd1;
                    col      <= '0;
                    ram_addr <= {row + 5'd1, 7'd0};
                    state    <= FETCH;
                  end
                end
                default: state <= IDLE;
              endcase
            end
          end
        end
        FINISH: begin
          done    <= 1'b1;
          busy    <= 1'b0;
          abort_q <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule
